// File: rtl/stall_fifo.sv
// Circular-buffer FIFO with registered status, optional full-passthrough
// (enq accepted alongside deq when full) and sticky overflow/underflow flags.
module stall_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int AFULL_LVL = DEPTH - 1,
    parameter int PASSTHRU  = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           inputs,
    input  logic                       enq,
    input  logic                       deq,
    output logic [WIDTH-1:0]           outputs,
    output logic                       enq_ready,
    output logic                       buffer_empty,
    output logic                       buffer_full,
    output logic                       almost_full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             deq_acc;
    logic             enq_acc;

    // Pointers wrap at DEPTH-1, so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign buffer_empty = (count == '0);
    assign buffer_full  = (count == CNT_W'(DEPTH));
    assign almost_full  = (count >= CNT_W'(AFULL_LVL));

    assign deq_acc   = deq && !buffer_empty;
    assign enq_ready = !buffer_full || ((PASSTHRU != 0) && deq_acc);
    assign enq_acc   = enq && enq_ready;

    // Stale storage behind an empty FIFO is masked so it can never leak out.
    assign outputs = buffer_empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (enq_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (deq_acc) rd_ptr <= ptr_inc(rd_ptr);
            case ({enq_acc, deq_acc})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (enq && !enq_ready) overflow  <= 1'b1;
            if (deq && buffer_empty) underflow <= 1'b1;
        end
    end

    // Storage is data-only: no reset, written only on a real accepted enq.
    always_ff @(posedge clk) begin
        if (enq_acc && reset && !flush) mem[wr_ptr] <= inputs;
    end

endmodule

// File: tb/tb_stall_fifo.sv
// Scoreboard bench for stall_fifo: three builds (passthru, no-passthru,
// DEPTH=3) share one stimulus stream and are each tracked by a queue model.
module tb_stall_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        enq = 1'b0;
    logic        deq = 1'b0;
    logic [31:0] inputs = '0;

    logic [31:0] o_out [3];
    logic        o_rdy [3];
    logic        o_emp [3];
    logic        o_ful [3];
    logic        o_afl [3];
    logic        o_ovf [3];
    logic        o_unf [3];
    logic [2:0]  cnt0, cnt1;
    logic [1:0]  cnt2;
    logic [31:0] o_cnt [3];

    int          depth [3] = '{4, 4, 3};
    int          pt    [3] = '{1, 0, 1};
    int          afl   [3] = '{3, 3, 2};
    logic [31:0] mq    [3][$];
    logic        m_ovf [3];
    logic        m_unf [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stall_fifo #(.WIDTH(32), .DEPTH(4), .AFULL_LVL(3), .PASSTHRU(1)) dut0 (
        .clk(clk), .reset(reset), .flush(flush), .inputs(inputs), .enq(enq), .deq(deq),
        .outputs(o_out[0]), .enq_ready(o_rdy[0]), .buffer_empty(o_emp[0]),
        .buffer_full(o_ful[0]), .almost_full(o_afl[0]), .count(cnt0),
        .overflow(o_ovf[0]), .underflow(o_unf[0]));

    stall_fifo #(.WIDTH(32), .DEPTH(4), .AFULL_LVL(3), .PASSTHRU(0)) dut1 (
        .clk(clk), .reset(reset), .flush(flush), .inputs(inputs), .enq(enq), .deq(deq),
        .outputs(o_out[1]), .enq_ready(o_rdy[1]), .buffer_empty(o_emp[1]),
        .buffer_full(o_ful[1]), .almost_full(o_afl[1]), .count(cnt1),
        .overflow(o_ovf[1]), .underflow(o_unf[1]));

    stall_fifo #(.WIDTH(32), .DEPTH(3), .AFULL_LVL(2), .PASSTHRU(1)) dut2 (
        .clk(clk), .reset(reset), .flush(flush), .inputs(inputs), .enq(enq), .deq(deq),
        .outputs(o_out[2]), .enq_ready(o_rdy[2]), .buffer_empty(o_emp[2]),
        .buffer_full(o_ful[2]), .almost_full(o_afl[2]), .count(cnt2),
        .overflow(o_ovf[2]), .underflow(o_unf[2]));

    assign o_cnt[0] = 32'(cnt0);
    assign o_cnt[1] = 32'(cnt1);
    assign o_cnt[2] = 32'(cnt2);

    task automatic check(input string tag, input int idx, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%h exp=%h at %0t", tag, idx, got, exp, $time);
        end
    endtask

    // One clock of stimulus: predict the combinational results before the
    // edge, advance the models at the edge, then compare the registered state.
    task automatic cyc(input logic e, input logic d, input logic [31:0] v,
                       input logic f = 1'b0, input logic r = 1'b1);
        logic emp [3];
        logic rdy [3];
        logic dacc [3];
        logic eacc [3];
        @(negedge clk);
        enq = e; deq = d; inputs = v; flush = f; reset = r;
        #1;
        for (int i = 0; i < 3; i++) begin
            emp[i]  = (mq[i].size() == 0);
            dacc[i] = d && !emp[i];
            rdy[i]  = (mq[i].size() != depth[i]) || ((pt[i] != 0) && dacc[i]);
            eacc[i] = e && rdy[i];
            check("enq_ready", i, 32'(o_rdy[i]), 32'(rdy[i]));
            if (dacc[i]) check("deq_data", i, o_out[i], mq[i][0]);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (!r || f) begin
                mq[i].delete();
                m_ovf[i] = 1'b0;
                m_unf[i] = 1'b0;
            end else begin
                if (dacc[i]) void'(mq[i].pop_front());
                if (eacc[i]) mq[i].push_back(v);
                if (e && !rdy[i]) m_ovf[i] = 1'b1;
                if (d && emp[i]) m_unf[i] = 1'b1;
            end
            check("count", i, o_cnt[i], 32'(mq[i].size()));
            check("empty", i, 32'(o_emp[i]), 32'(mq[i].size() == 0));
            check("full", i, 32'(o_ful[i]), 32'(mq[i].size() == depth[i]));
            check("afull", i, 32'(o_afl[i]), 32'(mq[i].size() >= afl[i]));
            check("overflow", i, 32'(o_ovf[i]), 32'(m_ovf[i]));
            check("underflow", i, 32'(o_unf[i]), 32'(m_unf[i]));
            check("head", i, o_out[i], (mq[i].size() == 0) ? 32'h0 : mq[i][0]);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_ovf[i] = 1'b0;
            m_unf[i] = 1'b0;
        end
        repeat (2) @(posedge clk);

        // Reset state, with enq ready out of reset
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("rst_count_const", 0, o_cnt[0], 32'd0);
        check("rst_rdy_const", 0, 32'(o_rdy[0]), 32'd1);

        // In-order fill and drain
        cyc(1'b1, 1'b0, 32'hA);
        cyc(1'b1, 1'b0, 32'hB);
        cyc(1'b1, 1'b0, 32'hC);
        check("afull_at3_const", 0, 32'(o_afl[0]), 32'd1);
        cyc(1'b1, 1'b0, 32'hD);
        check("full_at4_const", 0, 32'(o_ful[0]), 32'd1);
        check("head_a_const", 0, o_out[0], 32'hA);
        repeat (4) cyc(1'b0, 1'b1, 32'h0);
        check("drained_const", 0, o_cnt[0], 32'd0);

        // Full FIFO with enq+deq: passthrough vs. rejection
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b0, 32'hA);
        cyc(1'b1, 1'b0, 32'hB);
        cyc(1'b1, 1'b0, 32'hC);
        cyc(1'b1, 1'b0, 32'hD);
        cyc(1'b1, 1'b1, 32'hE);
        check("pt1_count_const", 0, o_cnt[0], 32'd4);
        check("pt1_ovf_const", 0, 32'(o_ovf[0]), 32'd0);
        check("pt0_count_const", 1, o_cnt[1], 32'd3);
        check("pt0_ovf_const", 1, 32'(o_ovf[1]), 32'd1);
        repeat (5) cyc(1'b0, 1'b1, 32'h0);

        // Empty FIFO with enq+deq: underflow, no bypass
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b1, 32'h5);
        check("unf_const", 0, 32'(o_unf[0]), 32'd1);
        check("unf_head_const", 0, o_out[0], 32'h5);
        cyc(1'b0, 1'b1, 32'h0);

        // Pointer wrap with steady enq/deq, then random traffic
        for (int k = 0; k < 12; k++) cyc(1'b1, k >= 2, 32'h100 + 32'(k));
        repeat (3) cyc(1'b0, 1'b1, 32'h0);
        for (int k = 0; k < 60; k++)
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);

        // Count 3 with overflow, then flush with enq
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 32'h200 + 32'(k));
        cyc(1'b0, 1'b1, 32'h0);
        check("pre_flush_cnt_const", 0, o_cnt[0], 32'd3);
        cyc(1'b1, 1'b0, 32'h77, 1'b1);
        check("flush_out_const", 0, o_out[0], 32'h0);

        // Count 2, reset asserted with enq
        cyc(1'b1, 1'b0, 32'h31);
        cyc(1'b1, 1'b0, 32'h32);
        cyc(1'b1, 1'b1, 32'h33, 1'b0, 1'b0);
        check("rst_empty_const", 0, 32'(o_emp[0]), 32'd1);
        cyc(1'b1, 1'b0, 32'h44);
        cyc(1'b0, 1'b1, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
